// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the BCD preset counter controller.
// Holds the FSM state encoding and the BCD range limits.
package bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_RUN    = 2'd3
  } ctrl_state_t;

  localparam logic [3:0]  BCD_MAX   = 4'd9;
  localparam logic [3:0]  BCD_MIN   = 4'd0;
  localparam int unsigned PERIODS_W = 8;

  // A preset is usable only if it is a legal BCD digit.
  function automatic logic is_bcd(input logic [3:0] v);
    return (v <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_preset_ctrl_sat_cnt8.sv
// Saturating event counter that holds at all-ones instead of wrapping.
// A clear request takes priority over an increment.
module sat_cnt8
  import bcd_ctrl_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clr,
  input  logic                 inc,
  output logic [PERIODS_W-1:0] count
);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + PERIODS_W'(1);
    end
  end

endmodule

// File: rtl/bcd_preset_ctrl.sv
// Controller that presets an external BCD up/down counter, verifies the load
// and then runs it, reporting each terminal count.
module bcd_preset_ctrl
  import bcd_ctrl_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 STOP,
  input  logic                 DIR,
  input  logic                 REPEAT,
  input  logic [3:0]           PRESET,
  input  logic [3:0]           Q,
  input  logic                 MAX_MIN,
  output logic                 LOAD,
  output logic                 CE,
  output logic                 UP_DOWN,
  output logic                 P0,
  output logic                 P1,
  output logic                 P2,
  output logic                 P3,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [PERIODS_W-1:0] PERIODS,
  output logic                 ERR
);

  ctrl_state_t state;
  logic [3:0]  preset_q;
  logic        repeat_q;
  logic        cnt_clr;
  logic        cnt_inc;

  // The counter expects the preset MSB on P0.
  assign P0 = preset_q[3];
  assign P1 = preset_q[2];
  assign P2 = preset_q[1];
  assign P3 = preset_q[0];

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (!STOP) begin
      cnt_clr = (state == ST_IDLE) && START && is_bcd(PRESET);
      cnt_inc = (state == ST_RUN) && MAX_MIN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      LOAD     <= 1'b1;
      CE       <= 1'b1;
      UP_DOWN  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      preset_q <= BCD_MIN;
      repeat_q <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (STOP) begin
        // Abort wins over everything; PERIODS and ERR keep their values.
        state <= ST_IDLE;
        LOAD  <= 1'b1;
        CE    <= 1'b1;
        BUSY  <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (START) begin
              if (is_bcd(PRESET)) begin
                preset_q <= PRESET;
                repeat_q <= REPEAT;
                UP_DOWN  <= DIR;
                ERR      <= 1'b0;
                LOAD     <= 1'b0;
                BUSY     <= 1'b1;
                state    <= ST_LOAD;
              end else begin
                ERR <= 1'b1;
              end
            end
          end
          ST_LOAD: begin
            LOAD  <= 1'b1;
            state <= ST_VERIFY;
          end
          ST_VERIFY: begin
            if (Q != preset_q) begin
              ERR   <= 1'b1;
              BUSY  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              CE    <= 1'b0;
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (MAX_MIN) begin
              DONE <= 1'b1;
              if (!repeat_q) begin
                CE    <= 1'b1;
                BUSY  <= 1'b0;
                state <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  sat_cnt8 u_periods (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (PERIODS)
  );

endmodule

// File: tb/tb_bcd_preset_ctrl.sv
// Bench pairing the controller with a behavioural BCD up/down counter.
// Run-phase expectations go through a scoreboard queue; other checks are direct.
module tb_bcd_preset_ctrl;

  logic       CLK = 1'b0;
  logic       RST, START, STOP, DIR, REPEAT;
  logic [3:0] PRESET;
  logic [3:0] Q;
  logic       MAX_MIN;
  logic       LOAD, CE, UP_DOWN, P0, P1, P2, P3, BUSY, DONE, ERR;
  logic [7:0] PERIODS;

  logic [3:0] cnt_q = 4'd0;
  logic       force_en = 1'b0;
  logic [3:0] force_val = 4'd0;

  int checks = 0;
  int errors = 0;
  int load_lows = 0;
  int ce_lows = 0;

  typedef struct {
    logic [3:0] q;
    logic       done;
    logic       ce;
    logic [7:0] periods;
  } exp_t;

  exp_t sb[$];

  bcd_preset_ctrl dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .DIR(DIR),
    .REPEAT(REPEAT), .PRESET(PRESET), .Q(Q), .MAX_MIN(MAX_MIN),
    .LOAD(LOAD), .CE(CE), .UP_DOWN(UP_DOWN), .P0(P0), .P1(P1), .P2(P2),
    .P3(P3), .BUSY(BUSY), .DONE(DONE), .PERIODS(PERIODS), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // External BCD counter: synchronous load, active-low enable, wraps 9<->0.
  always @(posedge CLK) begin
    if (!LOAD) cnt_q <= {P0, P1, P2, P3};
    else if (!CE) begin
      if (UP_DOWN) cnt_q <= (cnt_q == 4'd0) ? 4'd9 : cnt_q - 4'd1;
      else         cnt_q <= (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
    end
  end
  assign Q       = force_en ? force_val : cnt_q;
  assign MAX_MIN = UP_DOWN ? (cnt_q == 4'd0) : (cnt_q == 4'd9);

  always @(posedge CLK) begin
    if (!LOAD) load_lows++;
    if (!CE)   ce_lows++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues a START pulse; returns during the cycle after it was sampled.
  task automatic start_cmd(input logic [3:0] pv, input logic d, input logic r);
    START = 1'b1; PRESET = pv; DIR = d; REPEAT = r;
    tick();
    START = 1'b0;
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_q"},       Q,       e.q);
      check({tag, "_done"},    DONE,    e.done);
      check({tag, "_ce"},      CE,      e.ce);
      check({tag, "_periods"}, PERIODS, e.periods);
      tick();
    end
  endtask

  // Queues n run cycles for a counter started at p0 in direction d.
  task automatic push_run(input int p0, input logic d, input int n);
    int q, prev, per;
    exp_t e;
    per = 0; prev = -1;
    for (int k = 0; k < n; k++) begin
      q = d ? (p0 + 100 - k) % 10 : (p0 + k) % 10;
      e.done = (prev == (d ? 0 : 9));
      if (e.done) per++;
      e.q = 4'(q); e.ce = 1'b0; e.periods = 8'(per);
      sb.push_back(e);
      prev = q;
    end
  endtask

  initial begin
    int ll, cl;
    logic [3:0] qs;
    RST = 1'b0; START = 1'b0; STOP = 1'b0; DIR = 1'b0; REPEAT = 1'b0; PRESET = 4'd0;
    #1 RST = 1'b1;
    tick(2);
    check("rst_load", LOAD, 1'b1);
    check("rst_ce", CE, 1'b1);
    check("rst_busy", BUSY, 1'b0);
    check("rst_misc", {UP_DOWN, P0, P1, P2, P3, DONE, ERR}, 7'b0);
    check("rst_periods", PERIODS, 8'd0);
    RST = 1'b0;
    tick();

    // Single up run from 3.
    ll = load_lows;
    start_cmd(4'd3, 1'b0, 1'b0);
    check("t1_load_low", LOAD, 1'b0);
    check("t1_preset", {P0, P1, P2, P3}, 4'd3);
    check("t1_dir", UP_DOWN, 1'b0);
    check("t1_busy", BUSY, 1'b1);
    check("t1_ce_load", CE, 1'b1);
    tick();
    check("t1_verify_load", LOAD, 1'b1);
    check("t1_verify_q", Q, 4'd3);
    tick();
    push_run(3, 1'b0, 7);
    drain("t1");
    check("t1_done", DONE, 1'b1);
    check("t1_ce_off", CE, 1'b1);
    check("t1_idle", BUSY, 1'b0);
    check("t1_periods", PERIODS, 8'd1);
    tick();
    check("t1_done_pulse", DONE, 1'b0);
    check("t1_one_load", load_lows - ll, 1);

    // Repeating down run from 2, with START held high while busy.
    start_cmd(4'd2, 1'b1, 1'b1);
    check("t2_dir", UP_DOWN, 1'b1);
    check("t2_preset", {P0, P1, P2, P3}, 4'd2);
    tick();
    check("t2_verify_q", Q, 4'd2);
    tick();
    START = 1'b1; PRESET = 4'd5;
    push_run(2, 1'b1, 25);
    drain("t2");
    START = 1'b0;
    check("t2_periods", PERIODS, 8'd3);
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    check("t2_stop_ce", CE, 1'b1);
    check("t2_stop_busy", BUSY, 1'b0);
    check("t2_stop_periods", PERIODS, 8'd3);

    // Out-of-range preset.
    ll = load_lows;
    start_cmd(4'd12, 1'b0, 1'b0);
    check("t3_err", ERR, 1'b1);
    check("t3_busy", BUSY, 1'b0);
    tick(2);
    check("t3_no_load", load_lows - ll, 0);
    check("t3_idle", BUSY, 1'b0);

    // Load verification failure.
    cl = ce_lows;
    start_cmd(4'd4, 1'b0, 1'b0);
    check("t4_err_clr", ERR, 1'b0);
    force_en = 1'b1; force_val = 4'd5;
    tick();
    check("t4_forced_q", Q, 4'd5);
    tick();
    force_en = 1'b0;
    check("t4_err", ERR, 1'b1);
    check("t4_idle", BUSY, 1'b0);
    tick();
    check("t4_ce_never", ce_lows - cl, 0);

    // START and STOP together.
    ll = load_lows;
    START = 1'b1; STOP = 1'b1; PRESET = 4'd5;
    tick();
    START = 1'b0; STOP = 1'b0;
    check("t5_idle", BUSY, 1'b0);
    check("t5_err_hold", ERR, 1'b1);
    tick();
    check("t5_no_load", load_lows - ll, 0);

    // STOP mid-run; sampled on the edge that brings Q to 6.
    start_cmd(4'd3, 1'b0, 1'b0);
    check("t6_err_clr", ERR, 1'b0);
    tick(2);
    push_run(3, 1'b0, 2);
    drain("t6");
    check("t6_q5", Q, 4'd5);
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    check("t6_ce", CE, 1'b1);
    check("t6_q6", Q, 4'd6);
    check("t6_periods", PERIODS, 8'd0);
    tick(3);
    check("t6_q_hold", Q, 4'd6);

    // Asynchronous reset mid-run.
    start_cmd(4'd8, 1'b0, 1'b1);
    tick(2);
    push_run(8, 1'b0, 14);
    drain("t7");
    check("t7_periods", PERIODS, 8'd2);
    #2 RST = 1'b1;
    #1;
    check("t7_rst_load", LOAD, 1'b1);
    check("t7_rst_ce", CE, 1'b1);
    check("t7_rst_busy", BUSY, 1'b0);
    check("t7_rst_periods", PERIODS, 8'd0);
    check("t7_rst_misc", {UP_DOWN, P0, P1, P2, P3, DONE, ERR}, 7'b0);
    qs = Q;
    cl = ce_lows;
    tick();
    RST = 1'b0;
    tick(2);
    check("t7_q_frozen", Q, qs);
    check("t7_no_ce", ce_lows - cl, 0);

    // Preset already at terminal going down.
    start_cmd(4'd0, 1'b1, 1'b0);
    check("t8_dir", UP_DOWN, 1'b1);
    tick();
    check("t8_verify_q", Q, 4'd0);
    tick();
    check("t8_run_ce", CE, 1'b0);
    check("t8_run_done", DONE, 1'b0);
    tick();
    check("t8_done", DONE, 1'b1);
    check("t8_ce_off", CE, 1'b1);
    check("t8_periods", PERIODS, 8'd1);
    tick();
    check("t8_done_pulse", DONE, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_preset_ctrl.md
BCD_PRESET_CTRL -- requirements
Module: bcd_preset_ctrl

Interface
REQ-001 CLK  input  1  single clock; all state updates on rising edge.
REQ-002 RST  input  1  reset, asynchronous, active-high.
REQ-003 START  input  1  host request to load the preset and begin counting; sampled on CLK.
REQ-004 STOP  input  1  host abort; sampled on CLK; takes priority over START.
REQ-005 DIR  input  1  count direction: 0 = up, 1 = down; latched at START.
REQ-006 REPEAT  input  1  1 = keep running through terminal count; latched at START.
REQ-007 PRESET  input  4  BCD preset value (0-9); latched at START.
REQ-008 Q  input  4  counter present state, returned from the BCD up/down counter.
REQ-009 MAX_MIN  input  1  counter terminal flag: high while Q is 9 (up) or 0 (down).
REQ-010 LOAD  output  1  active-low parallel load strobe to the counter.
REQ-011 CE  output  1  active-low count enable to the counter.
REQ-012 UP_DOWN  output  1  direction to the counter; equals the latched DIR.
REQ-013 P0, P1, P2, P3  output  1 each  preset bits to the counter; P0 = PRESET[3] (MSB) ... P3 = PRESET[0].
REQ-014 BUSY  output  1  high in LOAD, VERIFY and RUN states.
REQ-015 DONE  output  1  one-cycle pulse at each terminal count.
REQ-016 PERIODS  output  8  count of terminal events since START; saturates at 255.
REQ-017 ERR  output  1  sticky error flag; cleared by the next accepted START or by RST.

Function
REQ-018 FSM states: IDLE, LOAD, VERIFY, RUN; all outputs registered.
REQ-019 IDLE: LOAD=1, CE=1, BUSY=0.
REQ-019a IDLE: START=1, STOP=0 and PRESET<=9 -> latch DIR/REPEAT/PRESET, clear PERIODS and ERR, go to LOAD.
REQ-020 IDLE: START with PRESET>9 -> set ERR and stay in IDLE; no LOAD pulse is issued.
REQ-021 LOAD: drive LOAD=0 for exactly one CLK cycle with P0-P3 and UP_DOWN valid; CE=1; then go to VERIFY.
REQ-022 VERIFY (one cycle, LOAD=1, CE=1): Q != latched PRESET -> set ERR and go to IDLE.
REQ-022a VERIFY: Q == latched PRESET -> go to RUN.
REQ-023 RUN: CE=0; each CLK with MAX_MIN=1 -> DONE=1 for one cycle; PERIODS increments with saturation at 255.
REQ-024 RUN, REPEAT=0: on the first MAX_MIN=1, deassert CE (CE=1) on the same edge that raises DONE; go to IDLE.
REQ-025 RUN, REPEAT=1: stay in RUN; the counter wraps 9->0 (up) or 0->9 (down) on its own.
REQ-026 A preset already at terminal (9 up, 0 down) counts as the first terminal event on the first RUN cycle.
REQ-027 STOP=1 in any state: go to IDLE next edge, LOAD=1, CE=1, DONE=0; PERIODS and ERR hold.
REQ-028 START while BUSY is ignored.
REQ-028a START and STOP in the same cycle: STOP wins.
REQ-029 Q and MAX_MIN are ignored outside VERIFY and RUN.

Reset
REQ-030 RST=1 forces state=IDLE, LOAD=1, CE=1, UP_DOWN=0, P0-P3=0, BUSY=0, DONE=0, PERIODS=0, ERR=0, asynchronously.
REQ-031 Reset mid-RUN or mid-LOAD: LOAD and CE return high immediately; no further counter action until a new START.

Structure
REQ-032 Shared package bcd_ctrl_pkg: FSM state type, BCD_MAX=9, BCD_MIN=0, PERIODS_W=8.
REQ-033 One sub-module, sat_cnt8: saturating 8-bit counter with clear and increment, used for PERIODS.
REQ-034 Intended pairing: CLK shared with the counter.
REQ-034a Counter connections: LOAD/CE/UP_DOWN/P0-P3 drive the counter; Q/MAX_MIN return from it.

Verification (bench instantiates the controller with the BCD up/down counter model)
REQ-035 PRESET=3, DIR=0, REPEAT=0, START -> one LOAD low cycle, Q=3 in VERIFY, counts 4..9, DONE once at Q=9, PERIODS=1, IDLE with CE=1.
REQ-036 PRESET=2, DIR=1, REPEAT=1, run 25 CLK in RUN -> Q sequence 1,0,9,8..., DONE at every Q=0, PERIODS=3.
REQ-037 PRESET=12, START -> ERR=1, LOAD never low, BUSY=0.
REQ-038 Q forced to 5 during VERIFY with PRESET=4 -> ERR=1, IDLE, CE never low.
REQ-039 START and STOP in the same cycle from IDLE -> remains IDLE.
REQ-039a STOP mid-RUN at Q=6 -> CE=1 next edge, Q holds 6, PERIODS unchanged.
REQ-040 RST pulse mid-RUN (REPEAT=1, PERIODS=2) -> outputs at reset values without waiting for a CLK edge.
REQ-040a After RST, START with PRESET=0, DIR=1 -> DONE on the first RUN cycle.
